// File: rtl/prog_loader_pkg.sv
// prog_loader_pkg -- shared types and default constants for the program loader.
//   state_t                 : loader FSM state encoding
//   ADDR_W_DEFAULT          : default instruction-memory address width
//   RELEASE_CYCLES_DEFAULT  : default number of cycles CPU reset is held after load
package prog_loader_pkg;

  localparam int ADDR_W_DEFAULT         = 8;
  localparam int RELEASE_CYCLES_DEFAULT = 4;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD,
    ST_WRITE,
    ST_HOLD,
    ST_RUN,
    ST_ERR
  } state_t;

endpackage

// File: rtl/prog_loader_if.sv
// prog_loader_if -- instruction stream input plus instruction-memory write port.
//   in_valid/in_word/in_last : incoming program words (driven by the source)
//   in_ready                 : loader accepts a word this cycle
//   mem_write/mem_addr/mem_din : write port into instruction memory
// Modports: slave = the loader, master = the word source / memory side.
interface prog_loader_if
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT
);

  logic              in_valid;
  logic [15:0]       in_word;
  logic              in_last;
  logic              in_ready;
  logic              mem_write;
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_din;

  modport slave (
    input  in_valid, in_word, in_last,
    output in_ready, mem_write, mem_addr, mem_din
  );

  modport master (
    output in_valid, in_word, in_last,
    input  in_ready, mem_write, mem_addr, mem_din
  );

endinterface

// File: rtl/prog_loader_cksum.sv
// prog_loader_cksum -- 16-bit modular accumulator of program data words.
//   clk, reset   : clock and asynchronous active-low reset
//   clear        : zero the accumulator (start of a new load)
//   accumulate   : add data to the running sum this cycle
//   data         : data word, also used as the candidate checksum word
//   sum_ok       : running sum plus data equals zero (combinational)
module prog_loader_cksum (
  input  logic        clk,
  input  logic        reset,
  input  logic        clear,
  input  logic        accumulate,
  input  logic [15:0] data,
  output logic        sum_ok
);

  logic [15:0] sum_reg;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sum_reg <= 16'h0000;
    end else if (clear) begin
      sum_reg <= 16'h0000;
    end else if (accumulate) begin
      sum_reg <= sum_reg + data;
    end
  end

  // Evaluated while the checksum word is on the input bus.
  assign sum_ok = ((sum_reg + data) == 16'h0000);

endmodule

// File: rtl/prog_loader.sv
// prog_loader -- streams program words into instruction memory while holding the
// CPU in reset, then releases the CPU after a fixed delay.
//   clk, reset   : clock and asynchronous active-low reset
//   start        : single-cycle request to begin a load (honoured in IDLE/RUN/ERR)
//   bus          : prog_loader_if.slave (word stream in, memory write port out)
//   cpu_reset    : active-high CPU reset, low only in RUN
//   done         : program loaded and CPU released
//   error        : load failed (memory overflow or bad checksum), held until start
//   word_count   : words written during the current load, saturating at 2^ADDR_W
// Optional build macro PROG_LOADER_CHECKSUM_EN: after the last word one extra
// checksum word is accepted; data words plus checksum must sum to zero mod 2^16.
module prog_loader
  import prog_loader_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEFAULT,
  parameter int RELEASE_CYCLES = RELEASE_CYCLES_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start,
  prog_loader_if.slave    bus,
  output logic            cpu_reset,
  output logic            done,
  output logic            error,
  output logic [ADDR_W:0] word_count
);

  localparam logic [ADDR_W-1:0] ADDR_MAX  = {ADDR_W{1'b1}};
  localparam logic [ADDR_W:0]   COUNT_MAX = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [15:0]       HOLD_LAST = 16'((RELEASE_CYCLES > 0) ? RELEASE_CYCLES - 1 : 0);

  state_t            state_reg, state_next;
  logic [ADDR_W-1:0] addr_reg, addr_next;
  logic [ADDR_W:0]   count_reg, count_next;
  logic [15:0]       din_reg, din_next;
  logic              last_reg, last_next;
  logic [15:0]       hold_reg, hold_next;
  logic              in_ready_c, mem_write_c;

`ifdef PROG_LOADER_CHECKSUM_EN
  logic cks_phase_reg, cks_phase_next;
  logic cks_ok;
  logic cks_clear;
  logic cks_accumulate;

  // A new load begins whenever start is honoured.
  assign cks_clear      = start && (state_reg inside {ST_IDLE, ST_RUN, ST_ERR});
  assign cks_accumulate = (state_reg == ST_LOAD) && bus.in_valid && !cks_phase_reg;

  prog_loader_cksum u_cksum (
    .clk        (clk),
    .reset      (reset),
    .clear      (cks_clear),
    .accumulate (cks_accumulate),
    .data       (bus.in_word),
    .sum_ok     (cks_ok)
  );
`endif

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg <= ST_IDLE;
      addr_reg  <= '0;
      count_reg <= '0;
      din_reg   <= 16'h0000;
      last_reg  <= 1'b0;
      hold_reg  <= 16'h0000;
`ifdef PROG_LOADER_CHECKSUM_EN
      cks_phase_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      addr_reg  <= addr_next;
      count_reg <= count_next;
      din_reg   <= din_next;
      last_reg  <= last_next;
      hold_reg  <= hold_next;
`ifdef PROG_LOADER_CHECKSUM_EN
      cks_phase_reg <= cks_phase_next;
`endif
    end
  end

  always_comb begin
    state_next  = state_reg;
    addr_next   = addr_reg;
    count_next  = count_reg;
    din_next    = din_reg;
    last_next   = last_reg;
    hold_next   = hold_reg;
    in_ready_c  = 1'b0;
    mem_write_c = 1'b0;
    cpu_reset   = 1'b1;
    done        = 1'b0;
    error       = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    cks_phase_next = cks_phase_reg;
`endif

    case (state_reg)
      ST_IDLE, ST_RUN, ST_ERR: begin
        if (state_reg == ST_RUN) begin
          cpu_reset = 1'b0;
          done      = 1'b1;
        end
        if (state_reg == ST_ERR) begin
          error = 1'b1;
        end
        if (start) begin
          state_next = ST_LOAD;
          addr_next  = '0;
          count_next = '0;
          last_next  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
          cks_phase_next = 1'b0;
`endif
        end
      end

      ST_LOAD: begin
        in_ready_c = 1'b1;
        if (bus.in_valid) begin
`ifdef PROG_LOADER_CHECKSUM_EN
          if (cks_phase_reg) begin
            // Checksum word: judged on the spot, never written or counted.
            cks_phase_next = 1'b0;
            hold_next      = 16'h0000;
            state_next     = cks_ok ? ST_HOLD : ST_ERR;
          end else
`endif
          begin
            din_next   = bus.in_word;
            last_next  = bus.in_last;
            state_next = ST_WRITE;
          end
        end
      end

      ST_WRITE: begin
        mem_write_c = 1'b1;
        if (count_reg != COUNT_MAX) begin
          count_next = count_reg + 1'b1;
        end
        if (last_reg) begin
          // Address only wraps through the overflow path.
          if (addr_reg != ADDR_MAX) begin
            addr_next = addr_reg + 1'b1;
          end
`ifdef PROG_LOADER_CHECKSUM_EN
          cks_phase_next = 1'b1;
          state_next     = ST_LOAD;
`else
          hold_next  = 16'h0000;
          state_next = ST_HOLD;
`endif
        end else if (addr_reg == ADDR_MAX) begin
          addr_next  = '0;
          state_next = ST_ERR;
        end else begin
          addr_next  = addr_reg + 1'b1;
          state_next = ST_LOAD;
        end
      end

      ST_HOLD: begin
        if (hold_reg == HOLD_LAST) begin
          state_next = ST_RUN;
        end else begin
          hold_next = hold_reg + 16'h0001;
        end
      end

      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  assign bus.in_ready  = in_ready_c;
  assign bus.mem_write = mem_write_c;
  assign bus.mem_addr  = addr_reg;
  assign bus.mem_din   = din_reg;
  assign word_count    = count_reg;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader -- directed self-checking bench for prog_loader.
// DUT A uses default parameters; DUT B uses ADDR_W=2 for the overflow case.
module tb_prog_loader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start_a = 1'b0;
  logic        start_b = 1'b0;
  logic        in_valid = 1'b0;
  logic [15:0] in_word = 16'h0000;
  logic        in_last = 1'b0;

  logic       cpu_reset_a, done_a, error_a;
  logic [8:0] word_count_a;
  logic       cpu_reset_b, done_b, error_b;
  logic [2:0] word_count_b;

  int total = 0;
  int passed = 0;

  logic [7:0]  log_a_addr[$];
  logic [15:0] log_a_data[$];
  logic [1:0]  log_b_addr[$];
  logic [15:0] log_b_data[$];

`ifdef PROG_LOADER_CHECKSUM_EN
  logic [15:0] sum_a = 16'h0000;
`endif

  always #5 clk = ~clk;

  prog_loader_if #(.ADDR_W(8)) a_if ();
  prog_loader_if #(.ADDR_W(2)) b_if ();

  assign a_if.in_valid = in_valid;
  assign a_if.in_word  = in_word;
  assign a_if.in_last  = in_last;
  assign b_if.in_valid = in_valid;
  assign b_if.in_word  = in_word;
  assign b_if.in_last  = in_last;

  prog_loader #(.ADDR_W(8), .RELEASE_CYCLES(4)) dut_a (
    .clk        (clk),
    .reset      (reset),
    .start      (start_a),
    .bus        (a_if.slave),
    .cpu_reset  (cpu_reset_a),
    .done       (done_a),
    .error      (error_a),
    .word_count (word_count_a)
  );

  prog_loader #(.ADDR_W(2), .RELEASE_CYCLES(4)) dut_b (
    .clk        (clk),
    .reset      (reset),
    .start      (start_b),
    .bus        (b_if.slave),
    .cpu_reset  (cpu_reset_b),
    .done       (done_b),
    .error      (error_b),
    .word_count (word_count_b)
  );

  // Memory write logger, sampled on the inactive edge.
  always @(negedge clk) begin
    if (a_if.mem_write === 1'b1) begin
      log_a_addr.push_back(a_if.mem_addr);
      log_a_data.push_back(a_if.mem_din);
      $display("A write addr=%0d data=%04h", a_if.mem_addr, a_if.mem_din);
    end
    if (b_if.mem_write === 1'b1) begin
      log_b_addr.push_back(b_if.mem_addr);
      log_b_data.push_back(b_if.mem_din);
      $display("B write addr=%0d data=%04h", b_if.mem_addr, b_if.mem_din);
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) passed++;
    else $error("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  task automatic pulse_start(input int which);
    if (which == 0) start_a = 1'b1; else start_b = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
  endtask

  // Wait for in_ready, optionally idle 'gap' cycles, then hand over one word.
  // Returns at the negedge following the handshake (WRITE state).
  task automatic send_word(input int which, input logic [15:0] w, input logic last, input int gap);
    int n = 0;
    logic rdy;
    in_valid = 1'b0;
    rdy = (which == 0) ? a_if.in_ready : b_if.in_ready;
    while (rdy !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
      rdy = (which == 0) ? a_if.in_ready : b_if.in_ready;
    end
    if (rdy !== 1'b1) begin
      check("ready_timeout", rdy, 1);
      return;
    end
    for (int g = 0; g < gap; g++) begin
      check("gap_in_ready", a_if.in_ready, 1);
      check("gap_mem_write", a_if.mem_write, 0);
      @(negedge clk);
    end
    in_valid = 1'b1;
    in_word  = w;
    in_last  = last;
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
`ifdef PROG_LOADER_CHECKSUM_EN
    if (which == 0) sum_a = sum_a + w;
`endif
  endtask

  // Called at the negedge of the final word's WRITE cycle on DUT A.
  task automatic finish_load_a();
    check("last_write_strobe", a_if.mem_write, 1);
`ifdef PROG_LOADER_CHECKSUM_EN
    begin
      int n = 0;
      send_word(0, 16'h0000 - sum_a, 1'b0, 0);
      while (done_a !== 1'b1 && n < 20) begin
        check("hold_cpu_reset", cpu_reset_a, 1);
        @(negedge clk);
        n++;
      end
    end
`else
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("hold_cpu_reset", cpu_reset_a, 1);
      check("hold_done", done_a, 0);
    end
    @(negedge clk);
`endif
    check("run_cpu_reset", cpu_reset_a, 0);
    check("run_done", done_a, 1);
  endtask

  task automatic check_a_reset_state(input string tag);
    check({tag, "_cpu_reset"}, cpu_reset_a, 1);
    check({tag, "_in_ready"}, a_if.in_ready, 0);
    check({tag, "_mem_write"}, a_if.mem_write, 0);
    check({tag, "_done"}, done_a, 0);
    check({tag, "_error"}, error_a, 0);
    check({tag, "_mem_addr"}, a_if.mem_addr, 0);
    check({tag, "_mem_din"}, a_if.mem_din, 0);
    check({tag, "_word_count"}, word_count_a, 0);
  endtask

  task automatic check_program_log(input string tag);
    check({tag, "_nwrites"}, log_a_addr.size(), 3);
    if (log_a_addr.size() == 3) begin
      check({tag, "_addr0"}, log_a_addr[0], 0);
      check({tag, "_data0"}, log_a_data[0], 16'hD002);
      check({tag, "_addr1"}, log_a_addr[1], 1);
      check({tag, "_data1"}, log_a_data[1], 16'h6140);
      check({tag, "_addr2"}, log_a_addr[2], 2);
      check({tag, "_data2"}, log_a_data[2], 16'hA0A1);
    end
  endtask

  initial begin
    // Reset held low with inputs toggling.
    for (int i = 0; i < 4; i++) begin
      start_a  = i[0];
      in_valid = ~i[0];
      in_word  = 16'(i * 16'h1111);
      in_last  = i[1];
      @(negedge clk);
      check_a_reset_state("reset_hold");
    end
    start_a = 1'b0; in_valid = 1'b0; in_last = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    check("idle_cpu_reset", cpu_reset_a, 1);
    check("idle_in_ready", a_if.in_ready, 0);

    // Back-to-back program load.
    $display("test: back-to-back load");
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_a = 16'h0000;
`endif
    pulse_start(0);
    check("load_in_ready", a_if.in_ready, 1);
    send_word(0, 16'hD002, 1'b0, 0);
    send_word(0, 16'h6140, 1'b0, 0);
    send_word(0, 16'hA0A1, 1'b1, 0);
    check("last_write_addr", a_if.mem_addr, 2);
    finish_load_a();
    check("p1_word_count", word_count_a, 3);
    check_program_log("p1");

    // Same program with idle gaps between words.
    $display("test: gapped load");
    log_a_addr.delete(); log_a_data.delete();
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_a = 16'h0000;
`endif
    pulse_start(0);
    check("restart_done", done_a, 0);
    check("restart_cpu_reset", cpu_reset_a, 1);
    send_word(0, 16'hD002, 1'b0, 3);
    send_word(0, 16'h6140, 1'b0, 3);
    send_word(0, 16'hA0A1, 1'b1, 3);
    finish_load_a();
    check("p2_word_count", word_count_a, 3);
    check_program_log("p2");

    // Memory overflow on the 4-word instance.
    $display("test: overflow ADDR_W=2");
    pulse_start(1);
    for (int i = 0; i < 4; i++) send_word(1, 16'h0100 + 16'(i), 1'b0, 0);
    @(negedge clk);
    check("ovf_error", error_b, 1);
    check("ovf_cpu_reset", cpu_reset_b, 1);
    check("ovf_in_ready", b_if.in_ready, 0);
    check("ovf_word_count", word_count_b, 4);
    in_valid = 1'b1; in_word = 16'h0104;
    repeat (3) @(negedge clk);
    in_valid = 1'b0;
    check("ovf_error_sticky", error_b, 1);
    check("ovf_done", done_b, 0);
    check("ovf_nwrites", log_b_addr.size(), 4);
    if (log_b_addr.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        check("ovf_addr", log_b_addr[i], 32'(i));
        check("ovf_data", log_b_data[i], 16'h0100 + 16'(i));
      end
    end

    // Reset in the middle of a load.
    $display("test: reset mid-load");
    log_a_addr.delete(); log_a_data.delete();
    pulse_start(0);
    send_word(0, 16'h1111, 1'b0, 0);
    send_word(0, 16'h2222, 1'b0, 0);
    @(negedge clk);
    in_valid = 1'b1; in_word = 16'h3333;
    #2 reset = 1'b0;
    #1;
    check_a_reset_state("async_reset");
    check("async_reset_b_error", error_b, 0);
    @(negedge clk);
    in_valid = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    check("midload_nwrites", log_a_addr.size(), 2);
    log_a_addr.delete(); log_a_data.delete();
`ifdef PROG_LOADER_CHECKSUM_EN
    sum_a = 16'h0000;
`endif
    pulse_start(0);
    send_word(0, 16'hBEEF, 1'b1, 0);
    check("reload_addr", a_if.mem_addr, 0);
    finish_load_a();
    check("reload_word_count", word_count_a, 1);
    check("reload_nwrites", log_a_addr.size(), 1);
    if (log_a_addr.size() == 1) begin
      check("reload_addr_log", log_a_addr[0], 0);
      check("reload_data_log", log_a_data[0], 16'hBEEF);
    end

`ifdef PROG_LOADER_CHECKSUM_EN
    // Good and bad checksum.
    $display("test: checksum");
    pulse_start(0);
    send_word(0, 16'h0001, 1'b0, 0);
    send_word(0, 16'h0002, 1'b1, 0);
    send_word(0, 16'hFFFD, 1'b0, 0);
    repeat (6) @(negedge clk);
    check("cks_good_done", done_a, 1);
    check("cks_good_count", word_count_a, 2);
    pulse_start(0);
    send_word(0, 16'h0001, 1'b0, 0);
    send_word(0, 16'h0002, 1'b1, 0);
    send_word(0, 16'hFFFC, 1'b0, 0);
    check("cks_bad_error", error_a, 1);
    check("cks_bad_done", done_a, 0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/prog_loader.md
PROG_LOADER -- requirements
Module: prog_loader

Interface
REQ-001 Parameter ADDR_W, default 8: instruction-memory address width; capacity 2^ADDR_W words.
REQ-002 Parameter RELEASE_CYCLES, default 4: cycles CPU reset is held after the final write.
REQ-003 clk  input  1  sole clock; all state updates on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle request to begin a program load.
REQ-006 in_valid  input  1  in_word/in_last hold a valid instruction word.
REQ-007 in_word  input  16  instruction word.
REQ-008 in_last  input  1  marks the final program word.
REQ-009 in_ready  output  1  loader accepts a word this cycle.
REQ-010 mem_write  output  1  write strobe to instruction memory.
REQ-011 mem_addr  output  ADDR_W  write address.
REQ-012 mem_din  output  16  write data.
REQ-013 cpu_reset  output  1  active-high reset to the CPU; high while loading.
REQ-014 done  output  1  program loaded and CPU released.
REQ-015 error  output  1  sticky load failure.
REQ-016 word_count  output  ADDR_W+1  number of words written this load.

Function
REQ-017 States IDLE, LOAD, WRITE, HOLD, RUN, ERR; one state per cycle.
REQ-018 IDLE: cpu_reset=1, in_ready=0; start -> LOAD, mem_addr=0, word_count=0, error cleared.
REQ-019 LOAD: in_ready=1; handshake (in_valid&in_ready) registers in_word into mem_din and in_last internally -> WRITE; no handshake -> stay.
REQ-020 WRITE: in_ready=0, mem_write=1 for exactly one cycle at current mem_addr; next edge word_count+1, mem_addr+1.
REQ-021 WRITE exit: stored last -> HOLD; else mem_addr was 2^ADDR_W-1 -> ERR; else -> LOAD.
REQ-022 Throughput one word per two cycles; mem_write never asserted outside WRITE.
REQ-023 HOLD: cpu_reset=1 for RELEASE_CYCLES cycles, then RUN.
REQ-024 RUN: cpu_reset=0, done=1; start -> LOAD with cpu_reset=1 and done=0 from the next cycle.
REQ-025 ERR: error=1, cpu_reset=1, in_ready=0; start -> LOAD (error cleared); otherwise stay.
REQ-026 start ignored in LOAD, WRITE, HOLD; in_valid ignored outside LOAD.
REQ-027 mem_addr wraps to 0 only via the ERR path; word_count saturates at 2^ADDR_W.

Reset
REQ-028 reset low asynchronously forces IDLE, cpu_reset=1, in_ready=0, mem_write=0, mem_addr=0, mem_din=0, done=0, error=0, word_count=0.
REQ-029 reset mid-load abandons the load; no partial write completes; next start restarts at address 0.

Configuration
REQ-030 Macro PROG_LOADER_CHECKSUM_EN defined: after the last word, LOAD accepts one extra checksum word (not written, not counted); 16-bit modular sum of data words plus checksum equal to 0 -> HOLD, else ERR.
REQ-031 Macro undefined: no checksum word; last word's WRITE goes directly to HOLD; no checksum logic synthesised.

Structure
REQ-032 Shared package prog_loader_pkg holds the state enumeration and default ADDR_W/RELEASE_CYCLES constants.
REQ-033 Single sub-module prog_loader_cksum (accumulator + zero compare), instantiated only under PROG_LOADER_CHECKSUM_EN.

Verification
REQ-034 Reset low with inputs toggling -> cpu_reset=1, in_ready=0, mem_write=0, done=0, error=0 immediately.
REQ-035 start; words 0xD002, 0x6140, 0xA0A1 (in_last on third), valid every cycle -> writes addr 0,1,2 with those data, cpu_reset falls 4 cycles after last write, done=1, word_count=3.
REQ-036 Same program with in_valid low 3 cycles between words -> identical writes, no mem_write during gaps, in_ready=1 throughout waits.
REQ-037 ADDR_W=2, 5 words without in_last -> 4 writes (addr 0..3), then error=1, cpu_reset=1, in_ready=0, fifth word not written.
REQ-038 reset low after 2 writes, then start and 1 word with in_last -> write at addr 0, word_count=1, done=1.
REQ-039 PROG_LOADER_CHECKSUM_EN: data 0x0001, 0x0002 then checksum 0xFFFD -> done=1, word_count=2; checksum 0xFFFC -> error=1, done=0.
